// File: rtl/sdp_pkg.sv
// rtl/sdp_pkg.sv - shared types and defaults for the shared add/sub issue arbiter
package sdp_pkg;

    localparam int SDP_NUM_REQ = 4;
    localparam int SDP_WIDTH   = 8;
    localparam int SDP_LATENCY = 3;
    // Tag ids are sized for the largest legal requester count (8).
    localparam int SDP_IDW     = 3;

    typedef struct packed {
        logic               vld;
        logic [SDP_IDW-1:0] id;
    } sdp_tag_t;

    typedef enum logic [1:0] {
        RUN,
        DRAINING,
        DRAINED
    } sdp_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: first request at or after ptr, wrapping at N-1
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o
);

    always_comb begin
        logic found;
        int   idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sdp_issue_arbiter.sv
// rtl/sdp_issue_arbiter.sv - shares one fixed-latency add/sub pipeline among NUM_REQ requesters
module sdp_issue_arbiter
    import sdp_pkg::*;
#(
    parameter int NUM_REQ = SDP_NUM_REQ,
    parameter int WIDTH   = SDP_WIDTH,
    parameter int LATENCY = SDP_LATENCY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_ctl_1,
    input  logic [NUM_REQ-1:0]       req_ctl_2,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_c,
    output logic                     dp_ctl_1,
    output logic                     dp_ctl_2,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic [WIDTH-1:0]         dp_c,
    input  logic [WIDTH-1:0]         dp_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     busy
);

    localparam int IDW = $clog2(NUM_REQ);

    sdp_arb_state_e     state_q;
    logic               drain_done_q;
    logic [IDW-1:0]     ptr_q, ptr_d;
    sdp_tag_t           tag_q [LATENCY];
    sdp_tag_t           tail;
    logic               arb_en;
    logic               grant_any;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;

    // Issue only while running and not being asked to drain; reset also masks the grant.
    assign arb_en = !reset && (state_q == RUN) && !drain_req;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr (
        .req_i    (req_valid & {NUM_REQ{arb_en}}),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req_ready = gnt;
    assign grant_any = |gnt;

    always_comb begin
        dp_ctl_1 = 1'b0;
        dp_ctl_2 = 1'b0;
        dp_a     = '0;
        dp_b     = '0;
        dp_c     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                dp_ctl_1 = req_ctl_1[i];
                dp_ctl_2 = req_ctl_2[i];
                dp_a     = req_a[i*WIDTH +: WIDTH];
                dp_b     = req_b[i*WIDTH +: WIDTH];
                dp_c     = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    assign tail = tag_q[LATENCY-1];

    always_comb begin
        busy      = 1'b0;
        rsp_valid = '0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | tag_q[i].vld;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tail.vld && (tail.id == SDP_IDW'(i));
        end
    end

    assign rsp_data   = tail.vld ? dp_out : '0;
    assign drain_done = drain_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
            ptr_q        <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            tag_q[0] <= '{vld: grant_any, id: SDP_IDW'(gnt_id)};
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            case (state_q)
                RUN: begin
                    if (drain_req) state_q <= DRAINING;
                end
                DRAINING: begin
                    // Dropping drain_req early resumes issue with in-flight tags kept.
                    if (!drain_req) begin
                        state_q <= RUN;
                    end else if (!busy) begin
                        state_q      <= DRAINED;
                        drain_done_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state_q      <= RUN;
                        drain_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= RUN;
                    drain_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_issue_arbiter.sv
// tb/tb_sdp_issue_arbiter.sv - randomized and directed check of sdp_issue_arbiter against a queue model
module tb_sdp_issue_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready, req_ctl_1, req_ctl_2, rsp_valid;
    logic [N*W-1:0] req_a, req_b, req_c;
    logic           dp_ctl_1, dp_ctl_2, drain_req, drain_done, busy;
    logic [W-1:0]   dp_a, dp_b, dp_c, dp_out, rsp_data;

    logic [W-1:0]   ra [N];
    logic [W-1:0]   rb [N];
    logic [W-1:0]   rc [N];
    logic [W-1:0]   dp_pipe [L];

    always #5 clk = ~clk;

    sdp_issue_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctl_1(req_ctl_1), .req_ctl_2(req_ctl_2),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .dp_ctl_1(dp_ctl_1), .dp_ctl_2(dp_ctl_2),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
            req_c[i*W +: W] = rc[i];
        end
    end

    function automatic logic [W-1:0] dp_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        logic [W-1:0] r;
        r = a[0] ? (a + b) : (a - b);
        return r - c;
    endfunction

    // 3-stage datapath partner: result appears LATENCY cycles after its inputs.
    always @(posedge clk) begin
        dp_pipe[0] <= dp_fn(dp_a, dp_b, dp_c);
        for (int i = 1; i < L; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_out = dp_pipe[L-1];

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] val;
    } pend_t;

    pend_t        q[$];
    int           m_ptr, m_state, cyc;
    int           n_tests, n_fail;
    logic [N-1:0] obs_rdy, obs_rv;
    logic [W-1:0] obs_rd;
    logic         obs_busy, obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        int           eg;
        int           idx;
        logic [N-1:0] exp_rdy, exp_rv;
        logic [W-1:0] exp_rd;
        logic [31:0]  exp_dp;
        logic         bsy;
        @(negedge clk);
        eg = -1;
        if (!reset && m_state == 0 && !drain_req) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (eg < 0 && req_valid[idx]) eg = idx;
            end
        end
        exp_rdy = '0;
        exp_dp  = '0;
        if (eg >= 0) begin
            exp_rdy[eg] = 1'b1;
            exp_dp = {6'd0, req_ctl_1[eg], req_ctl_2[eg], ra[eg], rb[eg], rc[eg]};
        end
        exp_rv = '0;
        exp_rd = '0;
        foreach (q[j]) if (q[j].due == cyc) begin
            exp_rv[q[j].id] = 1'b1;
            exp_rd = q[j].val;
        end
        bsy = (q.size() != 0);
        chk("req_ready", req_ready, exp_rdy);
        chk("dp_fields", {6'd0, dp_ctl_1, dp_ctl_2, dp_a, dp_b, dp_c}, exp_dp);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, exp_rd);
        chk("busy", busy, bsy);
        chk("drain_done", drain_done, m_state == 2);
        obs_rdy = req_ready; obs_rv = rsp_valid; obs_rd = rsp_data;
        obs_busy = busy; obs_done = drain_done;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ptr = 0;
            m_state = 0;
        end else begin
            for (int j = q.size() - 1; j >= 0; j--) if (q[j].due == cyc) q.delete(j);
            if (eg >= 0) begin
                q.push_back('{due: cyc + L, id: eg, val: dp_fn(ra[eg], rb[eg], rc[eg])});
                m_ptr = (eg + 1) % N;
            end
            case (m_state)
                0: if (drain_req) m_state = 1;
                1: if (!drain_req) m_state = 0; else if (!bsy) m_state = 2;
                default: if (!drain_req) m_state = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt [N];
        int n_rsp;
        logic seen_done;
        n_tests = 0; n_fail = 0; cyc = 0; m_ptr = 0; m_state = 0;
        reset = 1'b1; drain_req = 1'b0; req_valid = '0;
        req_ctl_1 = '0; req_ctl_2 = '0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = '0; end
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        chk("rst_ready", obs_rdy, 0);
        chk("rst_rsp", {obs_rv, obs_rd}, 0);
        chk("rst_busy_done", {obs_busy, obs_done}, 0);

        // odd a: (5+3)-1
        ra[0] = 8'd5; rb[0] = 8'd3; rc[0] = 8'd1; req_ctl_1 = 4'b0001;
        req_valid = 4'b0001; step();
        idle(3);
        chk("t1_rsp_valid", obs_rv, 4'b0001);
        chk("t1_rsp_data", obs_rd, 8'd7);

        // even a wraps: (4-6)-2
        ra[0] = 8'd4; rb[0] = 8'd6; rc[0] = 8'd2;
        req_valid = 4'b0001; step();
        idle(3);
        chk("t6_rsp_data", obs_rd, 8'hFC);

        // pointer to 2, then 1 and 3 contend: 3 first, wrap, then 1
        req_valid = 4'b0010; step();
        req_valid = 4'b1010; step();
        chk("t3_first", obs_rdy, 4'b1000);
        step();
        chk("t3_second", obs_rdy, 4'b0010);
        idle(3);

        for (int k = 0; k < N; k++) cnt[k] = 0;
        req_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < N; k++) begin
                ra[k] = W'($urandom); rb[k] = W'($urandom); rc[k] = W'($urandom);
            end
            step();
            for (int k = 0; k < N; k++) if (obs_rdy[k]) cnt[k]++;
        end
        for (int k = 0; k < N; k++) chk("t2_fair", cnt[k], 4);
        idle(3);

        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        drain_req = 1'b1;
        n_rsp = 0; seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            step();
            if (obs_rv != 0) n_rsp++;
            seen_done = obs_done;
        end
        chk("t4_rsps", n_rsp, 3);
        chk("t4_done", seen_done, 1'b1);
        drain_req = 1'b0;
        step();
        step();
        chk("t4_resume", obs_rdy != 0, 1'b1);
        idle(3);

        req_valid = 4'b0011; step(); step();
        reset = 1'b1; req_valid = 4'b1111; step();
        reset = 1'b0; req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_rsp", {obs_rv, obs_rd, obs_busy, obs_done}, 0);
        end

        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom_range(0, 15));
            req_ctl_1 = N'($urandom); req_ctl_2 = N'($urandom);
            for (int k = 0; k < N; k++) begin
                ra[k] = W'($urandom); rb[k] = W'($urandom); rc[k] = W'($urandom);
            end
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            step();
        end
        drain_req = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
